alu_sequencer: RTL
==================

Name: alu_sequencer

Overview:
Instruction-issuing front end for the 8-bit ALU: the initiator that drives the ALU's op/data_in1/data_in2 inputs and consumes its data_out. It accepts 16-bit instructions over a valid/ready handshake and holds a 4-entry x 8-bit register file. It drives operands and opcode to the ALU for a fixed settle window, then writes data_out back to the destination register. STORE instructions emit register contents on a result valid/ready port.

Parameters:
ALU_LAT, 1, cycles op/operands held stable before data_out is sampled (legal >=1)
IDLE_OP, 4'h0, opcode driven on alu_op when not executing
NREG, 4, register file depth (fixed; rd/rs fields are 2 bits)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
instr_valid  in  1  instruction available
instr_ready  out  1  sequencer can accept instruction
instr  in  16  instruction word
alu_op  out  4  to ALU op
alu_a  out  8  to ALU data_in1
alu_b  out  8  to ALU data_in2
alu_result  in  8  from ALU data_out (combinational path inside ALU)
res_valid  out  1  res_data valid
res_ready  in  1  result consumer ready
res_data  out  8  stored register value
busy  out  1  high whenever state != IDLE

Behaviour:
- Instruction format, kind = instr[15:14]:
  00 ALU: op=[13:10], rd=[9:8], rs1=[7:6], rs2=[5:4], [3:0] ignored.
  01 LOADI: rd=[9:8], imm=[7:0].
  10 STORE: rs1=[7:6].
  11 NOP.
- Reset (reset=0, async): state=IDLE; all regs=0; alu_op=IDLE_OP; alu_a=alu_b=0; res_valid=0; res_data=0; cycle counter=0. Reset mid-operation aborts the instruction: no write-back, any pending result is dropped.
- instr_ready = (state==IDLE); combinational from state only, never from instr_valid.
- Accept = instr_valid & instr_ready at a rising edge.
- States: IDLE, EXEC, OUT.
- IDLE, on accept:
  ALU -> EXEC. Registers alu_op=op, alu_a=R[rs1], alu_b=R[rs2], latches rd, cnt=ALU_LAT-1.
  LOADI -> R[rd]<=imm, stay IDLE. Back-to-back accepts allowed, 1 instr/cycle.
  STORE -> OUT. res_data<=R[rs1], res_valid<=1.
  NOP -> consumed, stay IDLE.
- EXEC: alu_op/alu_a/alu_b held constant. cnt>0 -> cnt-1. cnt==0 -> R[rd]<=alu_result, alu_op<=IDLE_OP, alu_a=alu_b<=0, ->IDLE.
- ALU instruction occupancy = ALU_LAT cycles in EXEC. Next accept is possible at edge k+ALU_LAT+1, where k is the accept edge.
- OUT: hold res_valid and res_data stable until res_valid & res_ready at an edge, then res_valid<=0 and ->IDLE. res_ready high on the first OUT cycle completes in 1 cycle. res_ready is ignored outside OUT.
- Operand reads use register values before the accept-edge write. An instruction following a LOADI to the same register sees the new value, since it is accepted at a later edge.
- rd==rs1 or rd==rs2: operands are captured at accept, so write-back does not disturb the running op.
- alu_result is taken as 8 bits verbatim. Compare ops return flags in bits [2:0] and zeros above; no interpretation is done here.
- Opcodes are passed through unchecked; unimplemented ALU slots write whatever alu_result shows.
- instr is sampled only at accept. Changes while instr_ready=0 are ignored.

Test Plan:
- Reset: hold reset=0 with instr_valid=1 -> instr_ready=1, busy=0, res_valid=0, alu_op=0, no register changes. Release, STORE R0..R3 -> res_data=0x00 each.
- LOADI R1=0x3C, LOADI R2=0x0F on consecutive cycles, then ALU op=8 (and) rd=R3 rs1=R1 rs2=R2, then STORE R3 -> alu_op=8, alu_a=0x3C, alu_b=0x0F for exactly ALU_LAT cycles; res_data=0x0C.
- ALU_LAT=3, ALU op=10 (or) R0=0xA0 | R1=0x05 into R0 -> instr_ready low 3 cycles, operands stable throughout, STORE R0 -> 0xA5.
- Compare op=5 with R1=0x10, R2=0x20 -> destination holds 0x00..0x07 pattern with bits[7:3]=0, matching the ALU's flag output.
- STORE with res_ready=0 for 5 cycles then 1 -> res_valid and res_data stable 6 cycles; single transfer; instr_ready returns the next cycle.
- Reset asserted mid-EXEC and mid-OUT -> immediate IDLE, res_valid=0, destination register=0, no write-back after release.

Source files
------------

// File: rtl/alu_sequencer.sv
// Instruction-issuing front end for the 8-bit ALU: 4 x 8-bit register file,
// LOADI/ALU/STORE/NOP decode, fixed ALU settle window and result handshake.
module alu_sequencer #(
  parameter int         ALU_LAT = 1,
  parameter logic [3:0] IDLE_OP = 4'h0,
  parameter int         NREG    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] instr,
  output logic [3:0]  alu_op,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  input  logic [7:0]  alu_result,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [7:0]  res_data,
  output logic        busy
);

  localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [CW-1:0] LAT_M1 = CW'(ALU_LAT - 1);

  localparam logic [1:0] KIND_ALU   = 2'b00;
  localparam logic [1:0] KIND_LOADI = 2'b01;
  localparam logic [1:0] KIND_STORE = 2'b10;

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, OUT = 2'd2} state_t;

  state_t        state_r;
  state_t        next_state_s;
  logic [7:0]    regs_r [NREG];
  logic [1:0]    rd_r;
  logic [CW-1:0] cnt_r;
  logic [3:0]    alu_op_r;
  logic [7:0]    alu_a_r;
  logic [7:0]    alu_b_r;
  logic          res_valid_r;
  logic [7:0]    res_data_r;
  logic          accept_s;
  logic [1:0]    kind_s;

  assign kind_s      = instr[15:14];
  assign instr_ready = (state_r == IDLE);
  assign busy        = (state_r != IDLE);
  assign accept_s    = instr_valid & instr_ready;
  assign alu_op      = alu_op_r;
  assign alu_a       = alu_a_r;
  assign alu_b       = alu_b_r;
  assign res_valid   = res_valid_r;
  assign res_data    = res_data_r;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          case (kind_s)
            KIND_ALU:   next_state_s = EXEC;
            KIND_STORE: next_state_s = OUT;
            default:    next_state_s = IDLE;
          endcase
        end else begin
          next_state_s = IDLE;
        end
      end
      EXEC: begin
        if (cnt_r == {CW{1'b0}}) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = EXEC;
        end
      end
      OUT: begin
        if (res_ready) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = OUT;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Register file, ALU drive registers and result port; operands read pre-write values
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= 8'h00;
      end
      rd_r        <= 2'd0;
      cnt_r       <= {CW{1'b0}};
      alu_op_r    <= IDLE_OP;
      alu_a_r     <= 8'h00;
      alu_b_r     <= 8'h00;
      res_valid_r <= 1'b0;
      res_data_r  <= 8'h00;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            case (kind_s)
              KIND_ALU: begin
                alu_op_r <= instr[13:10];
                alu_a_r  <= regs_r[instr[7:6]];
                alu_b_r  <= regs_r[instr[5:4]];
                rd_r     <= instr[9:8];
                cnt_r    <= LAT_M1;
              end
              KIND_LOADI: regs_r[instr[9:8]] <= instr[7:0];
              KIND_STORE: begin
                res_data_r  <= regs_r[instr[7:6]];
                res_valid_r <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        EXEC: begin
          if (cnt_r == {CW{1'b0}}) begin
            regs_r[rd_r] <= alu_result;
            alu_op_r     <= IDLE_OP;
            alu_a_r      <= 8'h00;
            alu_b_r      <= 8'h00;
          end else begin
            cnt_r <= cnt_r - CW'(1);
          end
        end
        OUT: begin
          if (res_ready) begin
            res_valid_r <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
